seq_divider_16_by_8: RTL

- Iterative restoring divider: unsigned dividend / unsigned divisor -> quotient and remainder, one quotient bit per clock.
- Inverse operation of the team's 8x8 Vedic multiplier. Intended to check a product c = a*b by dividing c back by b.
- Uses a valid/ready handshake on both the input and output sides. Accepts one operation at a time, with no overlap.

---
 rtl/seq_divider_pkg.sv | 21 ++
 rtl/seq_divider_16_by_8_div_step.sv | 30 +++
 rtl/seq_divider_16_by_8.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential 16-by-8 divider.
package seq_divider_pkg;

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  // The iteration counter must hold the value DIVIDEND_W itself.
  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_DIVIDEND_W);

endpackage

// File: rtl/seq_divider_16_by_8_div_step.sv
// One restoring-division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference when it does not borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] trial;

  // Trial subtract one bit wider than the remainder so the MSB is the borrow.
  // NOTE: every always_comb output gets a value on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    shifted = {rem_in[DIVISOR_W-1:0], bit_in};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    // A set MSB on the incoming remainder means the shifted value already
    // exceeds any divisor, so the subtract must succeed.
    q_bit   = rem_in[DIVISOR_W] | ~trial[DIVISOR_W+1];
    rem_out = q_bit ? trial[DIVISOR_W:0] : shifted;
  end

endmodule

// File: rtl/seq_divider_16_by_8.sv
// Iterative restoring divider, one quotient bit per clock, with valid/ready
// handshakes on both sides and a single operation in flight.
// DIVISOR_W must not exceed DIVIDEND_W.
module seq_divider_16_by_8
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = cnt_width(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;         // partial remainder
  logic [DIVIDEND_W-1:0] shreg_q, shreg_d;     // dividend bits out, quotient bits in
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (shreg_q[DIVIDEND_W-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvsr_d = divisor;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = '0;
            shreg_d = dividend;
            cnt_d   = CW'(DIVIDEND_W);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d   = step_rem;
        shreg_d = {shreg_q[DIVIDEND_W-2:0], step_q};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last step: publish quotient, remainder and flag on the same edge.
          quotient_d  = {shreg_q[DIVIDEND_W-2:0], step_q};
          remainder_d = step_rem[DIVISOR_W-1:0];
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the working registers are reset too; they are few and small, and a
  // known value after reset keeps the visible outputs deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      shreg_q     <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
